// File: rtl/system_qsy_nios2_qsys_oci_dct_monitor.sv
// rtl/system_qsy_nios2_qsys_oci_dct_monitor.sv - OCI DCT trace capture FIFO with end-of-test sequencing
module system_qsy_nios2_qsys_oci_dct_monitor #(
    parameter int ENTRY_W     = 2,
    parameter int NUM_ENTRIES = 15,
    parameter int CNT_W       = 4,
    parameter int DEPTH       = 8,
    localparam int BUF_W      = ENTRY_W * NUM_ENTRIES,
    localparam int LVL_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BUF_W-1:0] dct_buffer,
    input  logic [CNT_W-1:0] dct_count,
    input  logic             test_ending,
    input  logic             test_has_ended,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [BUF_W-1:0] rd_data,
    output logic [CNT_W-1:0] rd_count,
    output logic             rd_last,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow,
    output logic [15:0]      drop_cnt,
    output logic [1:0]       mon_state,
    output logic             done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_ENTRIES);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

    typedef enum logic [1:0] {RUN = 2'd0, ENDING = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] prev_count_q;
    logic             prev_ending_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q;
    logic [15:0]      drop_cnt_q;

    logic [BUF_W-1:0] mem_buf_q  [DEPTH];
    logic [CNT_W-1:0] mem_cnt_q  [DEPTH];
    logic             mem_last_q [DEPTH];

    logic in_run, full_evt, end_evt, push, pop, do_write, drop;

    assign in_run   = (state_q == RUN);
    assign full_evt = in_run && (dct_count == FULL_CNT) && (prev_count_q != FULL_CNT);
    assign end_evt  = in_run && ((test_ending && !prev_ending_q) || test_has_ended);
    assign push     = full_evt || end_evt;
    assign rd_valid = (level_q != '0);
    assign pop      = rd_valid && rd_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_write = push && ((level_q != LVL_FULL) || pop);
    assign drop     = push && !do_write;

    always_comb begin
        level_d = level_q;
        if (do_write && !pop)
            level_d = level_q + LVL_ONE;
        else if (!do_write && pop)
            level_d = level_q - LVL_ONE;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:    if (end_evt) state_d = test_has_ended ? DRAIN : ENDING;
            ENDING: if (test_has_ended) state_d = DRAIN;
            DRAIN:  if ((level_q == '0) || ((level_q == LVL_ONE) && pop)) state_d = DONE;
            default: state_d = DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            prev_count_q  <= '0;
            prev_ending_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            prev_count_q  <= dct_count;
            prev_ending_q <= test_ending;
            level_q       <= level_d;
            if (do_write) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)      rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_write) begin
            mem_buf_q[wr_ptr_q]  <= dct_buffer;
            mem_cnt_q[wr_ptr_q]  <= dct_count;
            mem_last_q[wr_ptr_q] <= end_evt;
        end
    end

    assign rd_data    = rd_valid ? mem_buf_q[rd_ptr_q]  : '0;
    assign rd_count   = rd_valid ? mem_cnt_q[rd_ptr_q]  : '0;
    assign rd_last    = rd_valid ? mem_last_q[rd_ptr_q] : 1'b0;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;
    assign mon_state  = state_q;
    assign done       = (state_q == DONE);
endmodule

// File: tb/tb_system_qsy_nios2_qsys_oci_dct_monitor.sv
// tb/tb_system_qsy_nios2_qsys_oci_dct_monitor.sv - scoreboard bench for the DCT monitor
module tb_system_qsy_nios2_qsys_oci_dct_monitor;
    logic        clk = 1'b0;
    logic        reset, test_ending, test_has_ended, rd_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        rd_valid, rd_last, overflow, done;
    logic [29:0] rd_data;
    logic [3:0]  rd_count, fifo_level;
    logic [15:0] drop_cnt;
    logic [1:0]  mon_state;

    typedef struct packed {
        logic [29:0] data;
        logic [3:0]  cnt;
        logic        last;
    } pkt_t;

    pkt_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    system_qsy_nios2_qsys_oci_dct_monitor dut (
        .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_count(rd_count), .rd_last(rd_last),
        .fifo_level(fifo_level), .overflow(overflow), .drop_cnt(drop_cnt),
        .mon_state(mon_state), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pkt(input logic [29:0] d, input logic [3:0] c, input logic l);
        pkt_t p;
        p.data = d;
        p.cnt  = c;
        p.last = l;
        sb.push_back(p);
    endtask

    // Monitor: every accepted head packet is compared against the scoreboard.
    always @(negedge clk) begin
        if (!reset && rd_valid && rd_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pkt: got data %0h cnt %0d, expected none", rd_data, rd_count);
            end else begin
                pkt_t e;
                e = sb.pop_front();
                chk("pkt_data", 64'(rd_data), 64'(e.data));
                chk("pkt_cnt", 64'(rd_count), 64'(e.cnt));
                chk("pkt_last", 64'(rd_last), 64'(e.last));
            end
        end
    end

    initial begin
        int waited;
        reset = 1'b1; test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;
        dct_buffer = '0; dct_count = '0;
        step(); step();
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_data", 64'(rd_data), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_state", 64'(mon_state), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b0;

        // 1: first full edge appears one cycle later at the head
        dct_buffer = 30'h2AAAAAAA; dct_count = 4'd15;
        expect_pkt(30'h2AAAAAAA, 4'd15, 1'b0);
        step();
        chk("t1_valid", 64'(rd_valid), 64'd1);
        chk("t1_data", 64'(rd_data), 64'h2AAAAAAA);
        chk("t1_cnt", 64'(rd_count), 64'd15);
        chk("t1_last", 64'(rd_last), 64'd0);
        chk("t1_level", 64'(fifo_level), 64'd1);

        // 2: holding count at full is a single edge
        repeat (4) step();
        chk("t2_level_hold", 64'(fifo_level), 64'd1);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("t2_level_pop", 64'(fifo_level), 64'd0);

        // 3: ten edges into an 8-deep FIFO, last two dropped
        for (int i = 0; i < 10; i++) begin
            dct_count = 4'(i % 15);
            step();
            dct_count = 4'd15;
            dct_buffer = 30'h01000000 + 30'(i);
            if (i < 8) expect_pkt(30'h01000000 + 30'(i), 4'd15, 1'b0);
            step();
        end
        chk("t3_level", 64'(fifo_level), 64'd8);
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_drop", 64'(drop_cnt), 64'd2);
        dct_count = 4'd0;
        rd_ready = 1'b1;
        waited = 0;
        while (fifo_level != 0 && waited < 20) begin
            step();
            waited++;
        end
        rd_ready = 1'b0;
        chk("t3_drained", 64'(fifo_level), 64'd0);
        chk("t3_drain_cycles", 64'(waited), 64'd8);

        // 4: two full packets, then test_ending rise with count 7
        dct_count = 4'd15; dct_buffer = 30'h0000000A;
        expect_pkt(30'h0000000A, 4'd15, 1'b0);
        step();
        dct_count = 4'd0;
        step();
        dct_count = 4'd15; dct_buffer = 30'h0000000B;
        expect_pkt(30'h0000000B, 4'd15, 1'b0);
        step();
        dct_count = 4'd7; dct_buffer = 30'h0000000C; test_ending = 1'b1;
        expect_pkt(30'h0000000C, 4'd7, 1'b1);
        step();
        chk("t4_level", 64'(fifo_level), 64'd3);
        chk("t4_state", 64'(mon_state), 64'd1);
        dct_count = 4'd0;
        step();
        dct_count = 4'd15;
        step();
        chk("t4_ignored", 64'(fifo_level), 64'd3);

        // 5: test_has_ended enters DRAIN; DONE follows the last pop
        test_has_ended = 1'b1;
        step();
        chk("t5_state", 64'(mon_state), 64'd2);
        rd_ready = 1'b1;
        step();
        chk("t5_done_a", 64'(done), 64'd0);
        step();
        chk("t5_done_b", 64'(done), 64'd0);
        step();
        rd_ready = 1'b0;
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_state_done", 64'(mon_state), 64'd3);
        chk("t5_level", 64'(fifo_level), 64'd0);

        // 6: reset out of DONE, then simultaneous full edge and ending rise
        reset = 1'b1; test_ending = 1'b0; test_has_ended = 1'b0; dct_count = 4'd0;
        step();
        chk("t6_rst_state", 64'(mon_state), 64'd0);
        chk("t6_rst_level", 64'(fifo_level), 64'd0);
        chk("t6_rst_ovf", 64'(overflow), 64'd0);
        chk("t6_rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        step();
        dct_count = 4'd15; dct_buffer = 30'h15555555; test_ending = 1'b1;
        expect_pkt(30'h15555555, 4'd15, 1'b1);
        step();
        chk("t6_level", 64'(fifo_level), 64'd1);
        chk("t6_cnt", 64'(rd_count), 64'd15);
        chk("t6_last", 64'(rd_last), 64'd1);
        chk("t6_state", 64'(mon_state), 64'd1);
        step();
        chk("t6_single", 64'(fifo_level), 64'd1);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("t6_popped", 64'(fifo_level), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
